// File: rtl/tcm_pkg.sv
// Shared types and helpers for the dual-port tightly-coupled memory.
package tcm_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } tcm_state_t;

    localparam int COLL_CNT_W = 16;
    localparam int MAX_DATA_W = 128;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/tcm_ram_core.sv
// Byte-enabled true-dual-port storage array with registered read ports.
// Reads return the word as it was before any write on the same edge;
// the caller resolves same-address write overlaps before they arrive here.
module tcm_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic [ADDR_WIDTH-1:0]   i_addr1,
    input  logic [DATA_WIDTH/8-1:0] i_we1,
    input  logic [DATA_WIDTH-1:0]   i_wdata1,
    output logic [DATA_WIDTH-1:0]   o_rdata1,
    input  logic [ADDR_WIDTH-1:0]   i_addr2,
    input  logic [DATA_WIDTH/8-1:0] i_we2,
    input  logic [DATA_WIDTH-1:0]   i_wdata2,
    output logic [DATA_WIDTH-1:0]   o_rdata2
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Lane writes for both ports plus registered reads of the pre-write word.
    // NOTE: the array has no reset branch so it maps onto block RAM; zeroing is done by the owner's sweep.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we2[b]) r_mem[i_addr2][b*8 +: 8] <= i_wdata2[b*8 +: 8];
            if (i_we1[b]) r_mem[i_addr1][b*8 +: 8] <= i_wdata1[b*8 +: 8];
        end
        o_rdata1 <= r_mem[i_addr1];
        o_rdata2 <= r_mem[i_addr2];
    end

endmodule

// File: rtl/tcm_dual_port.sv
// Dual Avalon-MM slave TCM: clear sweep FSM, port-1-priority write merge,
// same-cycle new-data forwarding, read latency pipe and collision counter.
module tcm_dual_port
    import tcm_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    chipselect2,
    input  logic                    read2,
    input  logic                    write2,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    waitrequest2,
    output logic                    busy,
    output logic [COLL_CNT_W-1:0]   collision_count
);
    localparam int BE_W = DATA_WIDTH / 8;

    tcm_state_t              r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic                    w_busy, w_same, w_coll;
    logic [1:0]              w_wr_acc, w_rd_acc;
    logic [ADDR_WIDTH-1:0]   w_ram_addr1;
    logic [BE_W-1:0]         w_ram_we1, w_ram_we2;
    logic [DATA_WIDTH-1:0]   w_ram_wdata1;
    logic [DATA_WIDTH-1:0]   w_q [2];
    logic [BE_W-1:0]         w_fwd_be [2];
    logic [DATA_WIDTH-1:0]   w_fwd_data [2];
    logic [DATA_WIDTH-1:0]   w_s1 [2];
    logic [BE_W-1:0]         r_fwd_be [2];
    logic [DATA_WIDTH-1:0]   r_fwd_data [2];
    logic [DATA_WIDTH-1:0]   r_out [2];
    logic                    r_rv1 [2];
    logic                    r_rv2 [2];
    logic [COLL_CNT_W-1:0]   r_coll;

    // State register and sweep pointer; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Next state: leave CLEAR once the last word has been zeroed.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && r_clr_ptr == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_READY;
    end

    assign w_busy       = (r_state == ST_CLEAR);
    assign busy         = w_busy;
    assign waitrequest  = w_busy;
    assign waitrequest2 = w_busy;

    // Accept decode, write-lane arbitration, collision detect and forwarding capture.
    always_comb begin
        w_wr_acc[0] = chipselect  & write  & ~w_busy;
        w_wr_acc[1] = chipselect2 & write2 & ~w_busy;
        w_rd_acc[0] = chipselect  & read  & ~write  & ~w_busy;
        w_rd_acc[1] = chipselect2 & read2 & ~write2 & ~w_busy;
        w_same      = (address == address2);
        w_coll      = w_wr_acc[0] & w_wr_acc[1] & w_same & (|(byteenable & byteenable2));

        w_ram_addr1  = w_busy ? r_clr_ptr : address;
        w_ram_wdata1 = w_busy ? '0 : writedata;
        w_ram_we1    = w_busy ? '1 : (w_wr_acc[0] ? byteenable : '0);
        w_ram_we2    = '0;
        if (w_wr_acc[1]) w_ram_we2 = (w_wr_acc[0] && w_same) ? (byteenable2 & ~byteenable) : byteenable2;

        // A reading port picks up the other port's same-address write lanes.
        w_fwd_be[0]   = (w_rd_acc[0] && w_wr_acc[1] && w_same) ? byteenable2 : '0;
        w_fwd_data[0] = writedata2;
        w_fwd_be[1]   = (w_rd_acc[1] && w_wr_acc[0] && w_same) ? byteenable : '0;
        w_fwd_data[1] = writedata;
    end

    tcm_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .i_addr1  (w_ram_addr1),
        .i_we1    (w_ram_we1),
        .i_wdata1 (w_ram_wdata1),
        .o_rdata1 (w_q[0]),
        .i_addr2  (address2),
        .i_we2    (w_ram_we2),
        .i_wdata2 (writedata2),
        .o_rdata2 (w_q[1])
    );

    // First-stage read word: RAM's pre-write data with forwarded lanes overlaid.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_s1[p] = DATA_WIDTH'(lane_merge(MAX_DATA_W'(w_q[p]), MAX_DATA_W'(r_fwd_data[p]),
                                             MAX_BE_W'(r_fwd_be[p])));
        end
    end

    // Read pipeline: valid/forwarding stage, then holding output register.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                r_rv1[p]      <= 1'b0;
                r_rv2[p]      <= 1'b0;
                r_fwd_be[p]   <= '0;
                r_fwd_data[p] <= '0;
                r_out[p]      <= '0;
            end else begin
                r_rv1[p]      <= w_rd_acc[p];
                r_rv2[p]      <= r_rv1[p];
                r_fwd_be[p]   <= w_fwd_be[p];
                r_fwd_data[p] <= w_fwd_data[p];
                if (r_rv1[p]) r_out[p] <= w_s1[p];
            end
        end
    end

    // Latency 1 presents stage-1 data directly; latency 2 presents the register.
    assign readdata       = (READ_LATENCY == 1 && r_rv1[0]) ? w_s1[0] : r_out[0];
    assign readdata2      = (READ_LATENCY == 1 && r_rv1[1]) ? w_s1[1] : r_out[1];
    assign readdatavalid  = (READ_LATENCY == 1) ? r_rv1[0] : r_rv2[0];
    assign readdatavalid2 = (READ_LATENCY == 1) ? r_rv1[1] : r_rv2[1];

    // Saturating count of overlapping same-address writes.
    always_ff @(posedge clk) begin
        if (reset)                          r_coll <= '0;
        else if (w_coll && r_coll != '1)    r_coll <= r_coll + 1'b1;
    end

    assign collision_count = r_coll;

endmodule

// File: tb/tb_tcm_dual_port.sv
// Self-checking bench: two DUTs (read latency 1 and 2) share stimulus and are
// compared against a word-array model that applies port 2 then port 1 writes.
module tb_tcm_dual_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs1, rd1, wr1, cs2, rd2, wr2;
    logic [8:0]  a1, a2;
    logic [3:0]  be1, be2;
    logic [31:0] wd1, wd2;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        rv1_a, rv2_a, rv1_b, rv2_b;
    logic        wt1_a, wt2_a, wt1_b, wt2_b, busy_a, busy_b;
    logic [15:0] cc_a, cc_b;

    // model state
    logic [31:0] mem [512];
    int          clr_left;
    int          coll;
    logic        ev1, ev2, pv1, pv2;
    logic [31:0] ed1, ed2, pd1, pd2;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    tcm_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset),
        .chipselect(cs1), .read(rd1), .write(wr1), .address(a1), .byteenable(be1),
        .writedata(wd1), .readdata(rd1_a), .readdatavalid(rv1_a), .waitrequest(wt1_a),
        .chipselect2(cs2), .read2(rd2), .write2(wr2), .address2(a2), .byteenable2(be2),
        .writedata2(wd2), .readdata2(rd2_a), .readdatavalid2(rv2_a), .waitrequest2(wt2_a),
        .busy(busy_a), .collision_count(cc_a)
    );

    tcm_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset),
        .chipselect(cs1), .read(rd1), .write(wr1), .address(a1), .byteenable(be1),
        .writedata(wd1), .readdata(rd1_b), .readdatavalid(rv1_b), .waitrequest(wt1_b),
        .chipselect2(cs2), .read2(rd2), .write2(wr2), .address2(a2), .byteenable2(be2),
        .writedata2(wd2), .readdata2(rd2_b), .readdatavalid2(rv2_b), .waitrequest2(wt2_b),
        .busy(busy_b), .collision_count(cc_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic cs, input logic r, input logic w, input logic [8:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        cs1 = cs; rd1 = r; wr1 = w; a1 = a; be1 = be; wd1 = d;
    endtask

    task automatic drive2(input logic cs, input logic r, input logic w, input logic [8:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        cs2 = cs; rd2 = r; wr2 = w; a2 = a; be2 = be; wd2 = d;
    endtask

    task automatic idle();
        drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive2(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic apply_write(input logic [8:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++) if (be[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic check_all();
        check("rv1",      32'(rv1_a),  32'(ev1));
        check("rd1",      rd1_a,       ed1);
        check("rv2",      32'(rv2_a),  32'(ev2));
        check("rd2",      rd2_a,       ed2);
        check("busy",     32'(busy_a), 32'(clr_left > 0));
        check("wait1",    32'(wt1_a),  32'(clr_left > 0));
        check("wait2",    32'(wt2_a),  32'(clr_left > 0));
        check("coll",     32'(cc_a),   32'(coll));
        check("rv1_lat2", 32'(rv1_b),  32'(pv1));
        check("rd1_lat2", rd1_b,       pd1);
        check("rv2_lat2", 32'(rv2_b),  32'(pv2));
        check("rd2_lat2", rd2_b,       pd2);
        check("busy_l2",  32'(busy_b), 32'(clr_left > 0));
        check("coll_l2",  32'(cc_b),   32'(coll));
    endtask

    // One clock: update the model from the driven request, advance, compare.
    task automatic step();
        bit acc1, acc2, w1, w2;
        acc1 = cs1 && (rd1 || wr1) && (clr_left == 0);
        acc2 = cs2 && (rd2 || wr2) && (clr_left == 0);
        w1   = acc1 && wr1;
        w2   = acc2 && wr2;
        pv1 = ev1; pd1 = ed1; pv2 = ev2; pd2 = ed2;
        if (w1 && w2 && a1 == a2 && (be1 & be2) != 0 && coll < 65535) coll++;
        if (w2) apply_write(a2, be2, wd2);
        if (w1) apply_write(a1, be1, wd1);
        ev1 = acc1 && rd1 && !wr1;
        ev2 = acc2 && rd2 && !wr2;
        if (ev1) ed1 = mem[a1];
        if (ev2) ed2 = mem[a2];
        @(posedge clk);
        #1;
        if (clr_left > 0) clr_left--;
        check_all();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        clr_left = 512;
        coll = 0;
        ev1 = 1'b0; ev2 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
        ed1 = '0; ed2 = '0; pd1 = '0; pd2 = '0;
        check_all();
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // Clear sweep: busy for exactly 512 cycles, memory reads back zero.
        do_reset();
        repeat (511) step();
        check("busy_last_clear", 32'(busy_a), 32'd1);
        step();
        check("busy_done", 32'(busy_a), 32'd0);
        drive2(1'b1, 1'b1, 1'b0, 9'd0, 4'hF, '0);   step(); check("clr_rd0",   rd2_a, 32'h0);
        drive2(1'b1, 1'b1, 1'b0, 9'd255, 4'hF, '0); step(); check("clr_rd255", rd2_a, 32'h0);
        drive2(1'b1, 1'b1, 1'b0, 9'd511, 4'hF, '0); step(); check("clr_rd511", rd2_a, 32'h0);
        idle(); step();

        // Cross-port write then read.
        drive1(1'b1, 1'b0, 1'b1, 9'd5, 4'hF, 32'hDEADBEEF); step(); idle();
        drive2(1'b1, 1'b1, 1'b0, 9'd5, 4'hF, '0); step(); idle();
        check("xport_rd_l1", rd2_a, 32'hDEADBEEF);
        check("xport_rv_l2_early", 32'(rv2_b), 32'd0);
        step();
        check("xport_rd_l2", rd2_b, 32'hDEADBEEF);
        check("xport_rv_l1_once", 32'(rv2_a), 32'd0);

        // Partial byte-enable and empty byte-enable writes.
        drive1(1'b1, 1'b0, 1'b1, 9'd3, 4'hF, 32'h12345678); step();
        drive1(1'b1, 1'b0, 1'b1, 9'd3, 4'h3, 32'h0000AAAA); step();
        drive1(1'b1, 1'b1, 1'b0, 9'd3, 4'hF, '0); step();
        check("be0011", rd1_a, 32'h1234AAAA);
        drive1(1'b1, 1'b0, 1'b1, 9'd3, 4'h0, 32'hFFFFFFFF);
        drive2(1'b1, 1'b0, 1'b1, 9'd3, 4'h0, 32'hFFFFFFFF); step(); idle();
        drive1(1'b1, 1'b1, 1'b0, 9'd3, 4'hF, '0); step(); idle();
        check("be0000", rd1_a, 32'h1234AAAA);
        check("be0000_coll", 32'(cc_a), 32'd0);

        // Same-address write collision: port 1 wins overlapping lanes.
        drive1(1'b1, 1'b0, 1'b1, 9'd7, 4'h3, 32'h11111111);
        drive2(1'b1, 1'b0, 1'b1, 9'd7, 4'hF, 32'h22222222); step(); idle();
        check("coll_one", 32'(cc_a), 32'd1);
        drive1(1'b1, 1'b1, 1'b0, 9'd7, 4'hF, '0); step(); idle();
        check("coll_word", rd1_a, 32'h22221111);
        drive1(1'b1, 1'b0, 1'b1, 9'd7, 4'h3, 32'h33333333);
        drive2(1'b1, 1'b0, 1'b1, 9'd7, 4'hC, 32'h44444444); step(); idle();
        check("coll_disjoint", 32'(cc_a), 32'd1);

        // Same-cycle write on port 1, read on port 2: new data forwarded.
        drive1(1'b1, 1'b0, 1'b1, 9'd9, 4'hF, 32'hCAFEF00D);
        drive2(1'b1, 1'b1, 1'b0, 9'd9, 4'hF, '0); step(); idle();
        check("fwd_new", rd2_a, 32'hCAFEF00D);
        step();
        check("fwd_new_l2", rd2_b, 32'hCAFEF00D);

        // Random traffic on a small address window to provoke overlaps.
        repeat (3000) begin
            drive1($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 9'($urandom_range(0, 15)),
                   4'($urandom), $urandom);
            drive2($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 9'($urandom_range(0, 15)),
                   4'($urandom), $urandom);
            step();
        end
        idle(); step();

        // Reset during sweep restarts it for a full 512 cycles.
        do_reset();
        repeat (100) step();
        do_reset();
        repeat (511) step();
        check("restart_busy", 32'(busy_a), 32'd1);
        step();
        check("restart_done", 32'(busy_a), 32'd0);

        // Counter saturation.
        drive1(1'b1, 1'b0, 1'b1, 9'd20, 4'hF, 32'hA5A5A5A5);
        drive2(1'b1, 1'b0, 1'b1, 9'd20, 4'hF, 32'h5A5A5A5A);
        repeat (65540) step();
        idle();
        check("coll_sat", 32'(cc_a), 32'h0000FFFF);
        drive1(1'b1, 1'b1, 1'b0, 9'd20, 4'hF, '0); step(); idle();
        check("sat_word", rd1_a, 32'hA5A5A5A5);
        do_reset();
        check("coll_cleared", 32'(cc_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
